// File: rtl/scaler_job_ctrl_pkg.sv
// Shared mode codes, FSM state encoding and framebuffer geometry defaults
// for the scaler job controller and its clear generator.
package scaler_job_ctrl_pkg;

  localparam logic [1:0] MODE_REP = 2'b00;
  localparam logic [1:0] MODE_DEC = 2'b01;
  localparam logic [1:0] MODE_NN  = 2'b10;
  localparam logic [1:0] MODE_AVG = 2'b11;

  localparam int FB_WORDS_DEF = 76800;
  localparam int ADDR_W_DEF   = 19;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_FIN   = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

endpackage

// File: rtl/scaler_job_ctrl_fb_clear_gen.sv
// Framebuffer clear address/write-enable generator: start loads address 0, one write per cycle,
// registered outputs, stops itself after the last word; stop_i kills the sweep the next cycle.
module fb_clear_gen
  import scaler_job_ctrl_pkg::*;
#(
  parameter int FB_WORDS = FB_WORDS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wren_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wren_q, wren_d;

  always_comb begin
    addr_d = addr_q;
    wren_d = wren_q;
    if (start_i) begin
      addr_d = '0;
      wren_d = 1'b1;
    end else if (stop_i) begin
      wren_d = 1'b0;
    end else if (wren_q) begin
      // The address parks on the last word rather than wrapping.
      if (addr_q == LAST_ADDR) begin
        wren_d = 1'b0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      wren_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      wren_q <= wren_d;
    end
  end

  assign addr_o = addr_q;
  assign wren_o = wren_q;
  assign last_o = wren_q && (addr_q == LAST_ADDR);

endmodule

// File: rtl/scaler_job_ctrl.sv
// Scaler job sequencer: IDLE -> CLEAR -> ARM -> RUN -> FIN/ERR; all outputs registered (one cycle
// from decision to output); start is ignored while a job is active, a select change aborts it.
module scaler_job_ctrl
  import scaler_job_ctrl_pkg::*;
#(
  parameter int         FB_WORDS   = FB_WORDS_DEF,
  parameter int         ADDR_W     = ADDR_W_DEF,
  parameter logic [7:0] CLR_VALUE  = 8'h00,
  parameter int         ARM_CYCLES = 2,
  parameter int         TIMEOUT    = 200000,
  parameter logic [3:0] MODE_MASK  = 4'b0011
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [1:0]        seletor_i,
  input  logic              eng_done_i,
  output logic [1:0]        eng_sel_o,
  output logic              eng_reset_o,
  output logic              ram_owner_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic [7:0]        clr_data_o,
  output logic              clr_wren_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int               ARM_W    = $clog2(ARM_CYCLES + 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);
  localparam int               TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       eng_sel_q, eng_sel_d;
  logic             eng_reset_q, eng_reset_d;
  logic             ram_owner_q, ram_owner_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic clr_start, clr_stop, clr_last, active, abort;

  fb_clear_gen #(
    .FB_WORDS (FB_WORDS),
    .ADDR_W   (ADDR_W)
  ) u_clear (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (clr_start),
    .stop_i  (clr_stop),
    .addr_o  (clr_addr_o),
    .wren_o  (clr_wren_o),
    .last_o  (clr_last)
  );

  assign active = (state_q == ST_CLEAR) || (state_q == ST_ARM) || (state_q == ST_RUN);
  assign abort  = active && (seletor_i != eng_sel_q);

  always_comb begin
    state_d     = state_q;
    eng_sel_d   = eng_sel_q;
    eng_reset_d = eng_reset_q;
    ram_owner_d = ram_owner_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    arm_cnt_d   = arm_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    clr_start   = 1'b0;
    clr_stop    = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      eng_reset_d = 1'b0;
      ram_owner_d = 1'b0;
      busy_d      = 1'b0;
      err_d       = 1'b0;
      clr_stop    = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            eng_sel_d = seletor_i;
            if (MODE_MASK[seletor_i]) begin
              state_d     = ST_CLEAR;
              err_d       = 1'b0;
              busy_d      = 1'b1;
              ram_owner_d = 1'b0;
              clr_start   = 1'b1;
            end else begin
              state_d     = ST_ERR;
              err_d       = 1'b1;
              eng_reset_d = 1'b0;
              ram_owner_d = 1'b0;
            end
          end
        end
        ST_CLEAR: begin
          if (clr_last) begin
            state_d     = ST_ARM;
            eng_reset_d = 1'b0;
            arm_cnt_d   = '0;
          end
        end
        ST_ARM: begin
          if (arm_cnt_q == ARM_LAST) begin
            state_d     = ST_RUN;
            eng_reset_d = 1'b1;
            ram_owner_d = 1'b1;
            tmo_cnt_d   = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
          end
        end
        ST_RUN: begin
          // A done flag left over from the previous job is masked on the first RUN cycle.
          if (eng_done_i && (tmo_cnt_q != '0)) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_d     = ST_ERR;
            err_d       = 1'b1;
            eng_reset_d = 1'b0;
            ram_owner_d = 1'b0;
            busy_d      = 1'b0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end
        ST_FIN:  state_d = ST_IDLE;
        ST_ERR:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      eng_sel_q   <= 2'b00;
      eng_reset_q <= 1'b0;
      ram_owner_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      arm_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      eng_sel_q   <= eng_sel_d;
      eng_reset_q <= eng_reset_d;
      ram_owner_q <= ram_owner_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      arm_cnt_q   <= arm_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign eng_sel_o   = eng_sel_q;
  assign eng_reset_o = eng_reset_q;
  assign ram_owner_o = ram_owner_q;
  assign clr_data_o  = CLR_VALUE;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_scaler_job_ctrl.sv
// Job-level bench for scaler_job_ctrl: each job's expected per-cycle outputs are derived from
// the job parameters (mode, done cycle, abort point) and checked cycle by cycle.
module tb_scaler_job_ctrl;
  import scaler_job_ctrl_pkg::*;

  localparam int         FB     = 8;
  localparam int         AW     = 19;
  localparam int         ARMC   = 2;
  localparam int         TMO    = 20;
  localparam logic [3:0] MASK   = 4'b0011;
  localparam logic [7:0] CLRV   = 8'h00;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    seletor_i = 2'b00;
  logic          eng_done_i = 1'b0;
  logic [1:0]    eng_sel_o;
  logic          eng_reset_o, ram_owner_o, clr_wren_o, busy_o, done_o, err_o;
  logic [AW-1:0] clr_addr_o;
  logic [7:0]    clr_data_o;

  int n_tot = 0;
  int n_bad = 0;

  // Values that persist between jobs in the model.
  logic [1:0] m_sel = 2'b00;
  logic       m_erst = 1'b0;
  logic       m_own = 1'b0;

  scaler_job_ctrl #(
    .FB_WORDS   (FB),
    .ADDR_W     (AW),
    .CLR_VALUE  (CLRV),
    .ARM_CYCLES (ARMC),
    .TIMEOUT    (TMO),
    .MODE_MASK  (MASK)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .seletor_i   (seletor_i),
    .eng_done_i  (eng_done_i),
    .eng_sel_o   (eng_sel_o),
    .eng_reset_o (eng_reset_o),
    .ram_owner_o (ram_owner_o),
    .clr_addr_o  (clr_addr_o),
    .clr_data_o  (clr_data_o),
    .clr_wren_o  (clr_wren_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic busy, input logic done, input logic err,
                         input logic wren, input logic erst, input logic own);
    chk({tag, ".busy"},  32'(busy_o),      32'(busy));
    chk({tag, ".done"},  32'(done_o),      32'(done));
    chk({tag, ".err"},   32'(err_o),       32'(err));
    chk({tag, ".wren"},  32'(clr_wren_o),  32'(wren));
    chk({tag, ".erst"},  32'(eng_reset_o), 32'(erst));
    chk({tag, ".owner"}, 32'(ram_owner_o), 32'(own));
    chk({tag, ".sel"},   32'(eng_sel_o),   32'(m_sel));
    chk({tag, ".data"},  32'(clr_data_o),  32'(CLRV));
  endtask

  task automatic step(input logic st, input logic [1:0] sel, input logic ed);
    start_i    = st;
    seletor_i  = sel;
    eng_done_i = ed;
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_abort(input logic [1:0] mode);
    m_erst = 1'b0;
    m_own  = 1'b0;
    chk_all("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, mode, 1'b0);
    chk_all("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // done_at: RUN cycle index from which eng_done is held high (>= TMO means never).
  // ab_ph: 0 none, 1 clear, 2 arm, 3 run, 4 async reset in run; ab_idx picks the cycle.
  task automatic run_job(input logic [1:0] mode, input int done_at, input int ab_ph,
                         input int ab_idx, input bit hold);
    logic [1:0] bad_sel;
    bit ab;
    logic ed;
    bad_sel = mode ^ 2'b01;
    step(1'b1, mode, 1'b0);
    m_sel = mode;
    if (!MASK[mode]) begin
      m_erst = 1'b0;
      m_own  = 1'b0;
      chk_all("unsup", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, mode, 1'b0);
      chk_all("unsup_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      return;
    end
    for (int i = 0; i < FB; i++) begin
      chk_all("clr", 1'b1, 1'b0, 1'b0, 1'b1, m_erst, 1'b0);
      chk("clr.addr", 32'(clr_addr_o), 32'(i));
      ab = (ab_ph == 1) && (ab_idx == i);
      step(hold && (i < 2), ab ? bad_sel : mode, 1'b0);
      if (ab) begin
        expect_abort(mode);
        return;
      end
    end
    m_erst = 1'b0;
    for (int j = 0; j < ARMC; j++) begin
      chk_all("arm", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      ab = (ab_ph == 2) && (ab_idx == j);
      step(1'b0, ab ? bad_sel : mode, 1'b0);
      if (ab) begin
        expect_abort(mode);
        return;
      end
    end
    m_erst = 1'b1;
    m_own  = 1'b1;
    for (int k = 0; k < TMO; k++) begin
      chk_all("run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      if ((ab_ph == 4) && (ab_idx == k)) begin
        #2 rst_ni = 1'b0;
        #1;
        m_sel = 2'b00;
        m_erst = 1'b0;
        m_own = 1'b0;
        chk_all("rst_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_run.addr", 32'(clr_addr_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        start_i = 1'b0;
        seletor_i = 2'b00;
        eng_done_i = 1'b0;
        @(posedge clk_i);
        #1;
        return;
      end
      ab = (ab_ph == 3) && (ab_idx == k);
      ed = (k >= done_at);
      step(1'b0, ab ? bad_sel : mode, ed);
      if (ab) begin
        expect_abort(mode);
        return;
      end
      if (ed && (k > 0)) begin
        chk_all("fin", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, mode, 1'b0);
        chk_all("fin_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        return;
      end
    end
    m_erst = 1'b0;
    m_own  = 1'b0;
    chk_all("tmo", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, mode, 1'b0);
    chk_all("tmo_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #12;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.addr", 32'(clr_addr_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b0, MODE_REP, 1'b0);
    chk_all("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    run_job(MODE_REP, 5,   0, 0, 1'b0);   // nominal
    run_job(MODE_DEC, 100, 0, 0, 1'b0);   // timeout
    run_job(MODE_NN,  5,   0, 0, 1'b0);   // unsupported
    run_job(MODE_AVG, 5,   0, 0, 1'b0);   // unsupported
    run_job(MODE_REP, 5,   1, 4, 1'b0);   // abort at clear address 4
    run_job(MODE_DEC, 100, 4, 3, 1'b0);   // async reset during RUN
    run_job(MODE_REP, 3,   0, 0, 1'b0);   // restart from address 0 after reset
    run_job(MODE_DEC, 4,   0, 0, 1'b1);   // start held during busy
    run_job(MODE_REP, 0,   0, 0, 1'b0);   // stale done on RUN entry
    run_job(MODE_DEC, TMO - 1, 0, 0, 1'b0); // done coincides with timeout
    run_job(MODE_REP, TMO, 0, 0, 1'b0);   // done one cycle too late
    run_job(MODE_DEC, 5,   2, 1, 1'b0);   // abort in ARM
    run_job(MODE_REP, 5,   3, 0, 1'b0);   // abort on first RUN cycle

    for (int n = 0; n < 60; n++) begin
      logic [1:0] md;
      int da, ph, ix;
      bit hd;
      md = 2'($urandom_range(0, 3));
      da = int'($urandom_range(0, TMO + 4));
      ph = int'($urandom_range(0, 7));
      if (ph > 3) ph = 0;
      ix = int'($urandom_range(0, TMO - 1));
      hd = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin
        step(1'b0, m_sel, 1'($urandom_range(0, 1)));
        chk("gap.busy", 32'(busy_o), 32'd0);
      end
      run_job(md, da, ph, ix, hd);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
